fx_dot_seq: RTL

Sequencer for the fixed-point multiply-accumulate datapath. It accepts a stream of signed weight/data pairs over a valid/ready handshake and groups them into dot products of exactly K terms. It drives the MAC pipeline (multiply, accumulate with first-term load), then rounds and saturates each result to WIDTH bits. Results are presented on a valid/ready output with backpressure. It sits between the layer-level data fetch and the activation/writeback stage.

---
 rtl/fx_dot_seq_pkg.sv | 25 ++
 rtl/fx_dot_seq_if.sv | 24 ++
 rtl/fx_dot_seq_round_sat.sv | 45 ++++
 rtl/fx_dot_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fx_dot_seq_pkg.sv
// Shared types and constants for the fixed-point dot-product sequencer:
// FSM state encoding, accumulator width derivation and saturation limits.
package fx_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        RND   = 2'd2,
        OUT   = 2'd3
    } fx_state_e;

    // Room for K full-scale products plus sign and rounding headroom
    function automatic int width_a(input int width, input int k);
        return $clog2(k) + 2 * width + 2;
    endfunction

    function automatic longint max_q(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint min_q(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fx_dot_seq_if.sv
// Operand-pair input stream and result output stream of the dot-product sequencer.
interface fx_dot_seq_if #(
    parameter int WIDTH = 8
);
    logic                    in_vld;
    logic                    in_rdy;
    logic signed [WIDTH-1:0] win;
    logic signed [WIDTH-1:0] din;
    logic                    out_vld;
    logic                    out_rdy;
    logic signed [WIDTH-1:0] acc_o;
    logic                    ovf_o;
    logic                    busy;

    modport master (
        output in_vld, win, din, out_rdy,
        input  in_rdy, out_vld, acc_o, ovf_o, busy
    );

    modport slave (
        input  in_vld, win, din, out_rdy,
        output in_rdy, out_vld, acc_o, ovf_o, busy
    );
endinterface

// File: rtl/fx_dot_seq_round_sat.sv
// Combinational round-half-up-on-sticky and clip of the wide accumulator
// down to a WIDTH-bit signed result with an overflow flag.
module fx_round_sat
    import fx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FRACTION = 4,
    parameter int WIDTH_A  = 21
) (
    input  logic signed [WIDTH_A-1:0] acc,
    output logic signed [WIDTH-1:0]   acc_o,
    output logic                      ovf_o
);

    localparam logic signed [WIDTH_A-1:0] MAX_A = WIDTH_A'(max_q(WIDTH));
    localparam logic signed [WIDTH_A-1:0] MIN_A = WIDTH_A'(min_q(WIDTH));

    logic                      guard_s;
    logic                      round_s;
    logic                      sticky_s;
    logic                      round_up_s;
    logic signed [WIDTH_A-1:0] shift_s;
    logic signed [WIDTH_A-1:0] q_s;

    // Round the dropped fraction, then clip into the signed result range
    always_comb begin
        guard_s    = acc[FRACTION-1];
        round_s    = acc[FRACTION-2];
        sticky_s   = |acc[FRACTION-3:0];
        round_up_s = guard_s & (round_s | sticky_s);
        shift_s    = acc >>> FRACTION;
        q_s        = shift_s + $signed({{(WIDTH_A-1){1'b0}}, round_up_s});
        if (q_s > MAX_A) begin
            acc_o = MAX_A[WIDTH-1:0];
            ovf_o = 1'b1;
        end else if (q_s < MIN_A) begin
            acc_o = MIN_A[WIDTH-1:0];
            ovf_o = 1'b1;
        end else begin
            acc_o = q_s[WIDTH-1:0];
            ovf_o = 1'b0;
        end
    end

endmodule

// File: rtl/fx_dot_seq.sv
// K-term signed dot-product sequencer: multiply, accumulate, round/saturate, hand off.
// Optional FX_DOT_SAT_CNT_EN adds a saturating count of overflowed results (sat_cnt).
module fx_dot_seq
    import fx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int K        = 8,
    parameter int WK       = $clog2(K),
    parameter int FRACTION = 4,
    parameter int WIDTH_A  = width_a(WIDTH, K)
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FX_DOT_SAT_CNT_EN
    output logic [15:0] sat_cnt,
`endif
    fx_dot_seq_if.slave bus
);

    fx_state_e                   state_r;
    fx_state_e                   state_s;
    logic [WK-1:0]               cnt_r;
    logic signed [2*WIDTH-1:0]   mult_r;
    logic                        first_r;
    logic                        pend_r;
    logic signed [WIDTH_A-1:0]   acc_r;
    logic signed [WIDTH-1:0]     acc_o_r;
    logic                        ovf_r;
    logic signed [WIDTH-1:0]     rs_acc_s;
    logic                        rs_ovf_s;
    logic                        beat_s;
    logic                        last_s;

    assign beat_s = bus.in_vld & (state_r == ACC);
    assign last_s = (cnt_r == WK'(K - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ACC;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ACC: begin
                if (beat_s && last_s) begin
                    state_s = FLUSH;
                end else begin
                    state_s = ACC;
                end
            end
            FLUSH:   state_s = RND;
            RND:     state_s = OUT;
            OUT: begin
                if (bus.out_rdy) begin
                    state_s = ACC;
                end else begin
                    state_s = OUT;
                end
            end
            default: state_s = ACC;
        endcase
    end

    // Beat counter, product register and accumulator; term 0 loads instead of adding
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {WK{1'b0}};
            mult_r  <= {(2*WIDTH){1'b0}};
            first_r <= 1'b0;
            pend_r  <= 1'b0;
            acc_r   <= {WIDTH_A{1'b0}};
        end else begin
            pend_r <= beat_s;
            if (beat_s) begin
                mult_r  <= bus.win * bus.din;
                first_r <= (cnt_r == {WK{1'b0}});
                cnt_r   <= last_s ? {WK{1'b0}} : cnt_r + WK'(1);
            end
            if (pend_r) begin
                if (first_r) begin
                    acc_r <= WIDTH_A'(mult_r);
                end else begin
                    acc_r <= acc_r + WIDTH_A'(mult_r);
                end
            end
        end
    end

    fx_round_sat #(
        .WIDTH    (WIDTH),
        .FRACTION (FRACTION),
        .WIDTH_A  (WIDTH_A)
    ) u_round_sat (
        .acc   (acc_r),
        .acc_o (rs_acc_s),
        .ovf_o (rs_ovf_s)
    );

    // Result register, captured once per vector and held through OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_o_r <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
        end else if (state_r == RND) begin
            acc_o_r <= rs_acc_s;
            ovf_r   <= rs_ovf_s;
        end
    end

`ifdef FX_DOT_SAT_CNT_EN
    // Count handed-off saturated results, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= 16'h0000;
        end else if ((state_r == OUT) && bus.out_rdy && ovf_r && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'h0001;
        end
    end
`endif

    assign bus.in_rdy  = (state_r == ACC);
    assign bus.out_vld = (state_r == OUT);
    assign bus.acc_o   = acc_o_r;
    assign bus.ovf_o   = ovf_r;
    assign bus.busy    = (state_r != ACC) | (cnt_r != {WK{1'b0}});

endmodule
